// File: rtl/dsl_sdram_arbiter.sv
// SDRAM access arbiter: schedules refresh, capture writes and USB readback
// onto a single command engine, one burst at a time.
module dsl_sdram_arbiter #(
  parameter int unsigned REFRESH_CYCLES = 937,
  parameter int unsigned ADDR_W         = 24,
  parameter int unsigned LEN_W          = 9,
  parameter int unsigned MAX_STARVE     = 4,
  parameter int unsigned RF_MAX         = 7
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [LEN_W-1:0]  wr_len,
  output logic              wr_gnt,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [LEN_W-1:0]  rd_len,
  output logic              rd_gnt,
  output logic              cmd_valid,
  output logic [1:0]        cmd_op,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_ack,
  input  logic              cmd_done,
  output logic              rf_overdue
);

  localparam int unsigned TMR_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int unsigned RFP_W = $clog2(RF_MAX + 1);
  localparam int unsigned STV_W = $clog2(MAX_STARVE + 1);

  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(REFRESH_CYCLES - 1);
  localparam logic [RFP_W-1:0] RFP_MAX    = RFP_W'(RF_MAX);
  localparam logic [STV_W-1:0] STV_MAX    = STV_W'(MAX_STARVE);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_WR = 2'b00,
    OP_RD = 2'b01,
    OP_RF = 2'b10
  } op_t;

  state_t            state_q, state_d;
  op_t               cmd_op_q, cmd_op_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [LEN_W-1:0]  cmd_len_q, cmd_len_d;
  logic              wr_gnt_q, wr_gnt_d;
  logic              rd_gnt_q, rd_gnt_d;
  logic [RFP_W-1:0]  rf_pend_q, rf_pend_d;
  logic              rf_overdue_q, rf_overdue_d;
  logic [STV_W-1:0]  starve_q, starve_d;
  logic [TMR_W-1:0]  timer_q, timer_d;

  logic sel_rf, sel_rd, sel_wr;
  logic wr_grant, rd_grant, rf_ack, rf_tick;

  // Source selection in IDLE; a starved reader jumps ahead of the writer.
  always_comb begin
    sel_rf = 1'b0;
    sel_rd = 1'b0;
    sel_wr = 1'b0;
    if (state_q == ST_IDLE) begin
      if (rf_pend_q != '0)                    sel_rf = 1'b1;
      else if (rd_req && starve_q == STV_MAX) sel_rd = 1'b1;
      else if (wr_req)                        sel_wr = 1'b1;
      else if (rd_req)                        sel_rd = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_valid_d = cmd_valid_q;
    cmd_op_d    = cmd_op_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_len_d   = cmd_len_q;
    wr_grant    = 1'b0;
    rd_grant    = 1'b0;
    rf_ack      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel_rf) begin
          cmd_op_d    = OP_RF;
          cmd_addr_d  = '0;
          cmd_len_d   = '0;
          cmd_valid_d = 1'b1;
          state_d     = ST_ISSUE;
        end else if (sel_wr) begin
          // Zero-length requests are granted here without touching the engine.
          if (wr_len == '0) begin
            wr_grant = 1'b1;
          end else begin
            cmd_op_d    = OP_WR;
            cmd_addr_d  = wr_addr;
            cmd_len_d   = wr_len;
            cmd_valid_d = 1'b1;
            state_d     = ST_ISSUE;
          end
        end else if (sel_rd) begin
          if (rd_len == '0) begin
            rd_grant = 1'b1;
          end else begin
            cmd_op_d    = OP_RD;
            cmd_addr_d  = rd_addr;
            cmd_len_d   = rd_len;
            cmd_valid_d = 1'b1;
            state_d     = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (cmd_ack) begin
          cmd_valid_d = 1'b0;
          wr_grant    = (cmd_op_q == OP_WR);
          rd_grant    = (cmd_op_q == OP_RD);
          rf_ack      = (cmd_op_q == OP_RF);
          state_d     = cmd_done ? ST_IDLE : ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cmd_done) state_d = ST_IDLE;
      end
      default: begin
        state_d     = ST_IDLE;
        cmd_valid_d = 1'b0;
      end
    endcase
    wr_gnt_d = wr_grant;
    rd_gnt_d = rd_grant;
  end

  always_comb begin
    starve_d = starve_q;
    if (rd_grant) begin
      starve_d = '0;
    end else if (wr_grant) begin
      if (!rd_req)                  starve_d = '0;
      else if (starve_q != STV_MAX) starve_d = starve_q + 1'b1;
    end
  end

  // A tick and a refresh ack in the same cycle cancel out.
  always_comb begin
    rf_tick      = (timer_q == '0);
    timer_d      = rf_tick ? TMR_RELOAD : timer_q - 1'b1;
    rf_pend_d    = rf_pend_q;
    rf_overdue_d = rf_overdue_q;
    if (rf_tick && !rf_ack) begin
      if (rf_pend_q == RFP_MAX) rf_overdue_d = 1'b1;
      else                      rf_pend_d    = rf_pend_q + 1'b1;
    end else if (rf_ack && !rf_tick) begin
      rf_pend_d = rf_pend_q - 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q      <= ST_IDLE;
      cmd_valid_q  <= 1'b0;
      cmd_op_q     <= OP_WR;
      cmd_addr_q   <= '0;
      cmd_len_q    <= '0;
      wr_gnt_q     <= 1'b0;
      rd_gnt_q     <= 1'b0;
      rf_pend_q    <= '0;
      rf_overdue_q <= 1'b0;
      starve_q     <= '0;
      timer_q      <= TMR_RELOAD;
    end else begin
      state_q      <= state_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_op_q     <= cmd_op_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_len_q    <= cmd_len_d;
      wr_gnt_q     <= wr_gnt_d;
      rd_gnt_q     <= rd_gnt_d;
      rf_pend_q    <= rf_pend_d;
      rf_overdue_q <= rf_overdue_d;
      starve_q     <= starve_d;
      timer_q      <= timer_d;
    end
  end

  assign wr_gnt     = wr_gnt_q;
  assign rd_gnt     = rd_gnt_q;
  assign cmd_valid  = cmd_valid_q;
  assign cmd_op     = cmd_op_q;
  assign cmd_addr   = cmd_addr_q;
  assign cmd_len    = cmd_len_q;
  assign rf_overdue = rf_overdue_q;

endmodule

// File: tb/tb_dsl_sdram_arbiter.sv
// Scoreboard bench for dsl_sdram_arbiter: expected commands and grants are
// queued as stimulus is issued and consumed by the engine model and grant monitor.
module tb_dsl_sdram_arbiter;

  localparam int unsigned RC = 937;
  localparam int unsigned AW = 24;
  localparam int unsigned LW = 9;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b0;
  logic          wr_req = 1'b0, rd_req = 1'b0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [LW-1:0] wr_len = '0, rd_len = '0;
  logic          wr_gnt, rd_gnt;
  logic          cmd_valid;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          cmd_ack = 1'b0, cmd_done = 1'b0;
  logic          rf_overdue;

  dsl_sdram_arbiter #(
    .REFRESH_CYCLES(RC),
    .ADDR_W(AW),
    .LEN_W(LW),
    .MAX_STARVE(4),
    .RF_MAX(7)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_gnt(rd_gnt),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_ack(cmd_ack), .cmd_done(cmd_done), .rf_overdue(rf_overdue)
  );

  always #4 sys_clk = ~sys_clk;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  logic [34:0] exp_cmd_q[$];
  byte         exp_gnt_q[$];
  int unsigned cmd_cyc_q[$];

  bit          eng_en   = 1'b1;
  int unsigned ack_dly  = 1;
  int unsigned done_dly = 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [34:0] mk(input logic [1:0] op, input logic [AW-1:0] a,
                                     input logic [LW-1:0] l);
    return {op, a, l};
  endfunction

  // Command engine model: accepts after ack_dly cycles, finishes done_dly cycles later.
  logic [34:0] eng_exp;
  initial begin
    forever begin
      @(negedge sys_clk);
      if (cmd_valid && eng_en) begin
        cmd_cyc_q.push_back(cyc);
        check("cmd_expected", 64'(exp_cmd_q.size() != 0), 64'd1);
        if (exp_cmd_q.size() != 0) begin
          eng_exp = exp_cmd_q.pop_front();
          check("cmd_fields", 64'({cmd_op, cmd_addr, cmd_len}), 64'(eng_exp));
        end
        repeat (ack_dly - 1) @(negedge sys_clk);
        cmd_ack = 1'b1;
        if (done_dly == 0) cmd_done = 1'b1;
        @(negedge sys_clk);
        cmd_ack  = 1'b0;
        cmd_done = 1'b0;
        if (done_dly > 0) begin
          repeat (done_dly - 1) @(negedge sys_clk);
          cmd_done = 1'b1;
          @(negedge sys_clk);
          cmd_done = 1'b0;
        end
      end
    end
  end

  task automatic gnt_seen(input byte g);
    check("gnt_expected", 64'(exp_gnt_q.size() != 0), 64'd1);
    if (exp_gnt_q.size() != 0) check("gnt_order", 64'(g), 64'(exp_gnt_q.pop_front()));
  endtask

  always @(negedge sys_clk) begin
    if (wr_gnt) gnt_seen(8'h57);
    if (rd_gnt) gnt_seen(8'h52);
  end

  task automatic req_xfer(input bit is_rd, input logic [AW-1:0] a, input logic [LW-1:0] l,
                          input int unsigned budget);
    bit got;
    if (is_rd) begin rd_req = 1'b1; rd_addr = a; rd_len = l; end
    else       begin wr_req = 1'b1; wr_addr = a; wr_len = l; end
    got = 1'b0;
    for (int unsigned i = 0; i < budget && !got; i++) begin
      @(negedge sys_clk);
      got = is_rd ? rd_gnt : wr_gnt;
    end
    check(is_rd ? "rd_gnt_wait" : "wr_gnt_wait", 64'(got), 64'd1);
  endtask

  task automatic do_reset();
    wr_req  = 1'b0;
    rd_req  = 1'b0;
    sys_rst = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b1;
  endtask

  task automatic queues_empty(input string tag);
    check({tag, "_cmdq"}, 64'(exp_cmd_q.size()), 64'd0);
    check({tag, "_gntq"}, 64'(exp_gnt_q.size()), 64'd0);
  endtask

  initial begin
    #(8 * 200000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          seen;
    int unsigned n;

    // Reset values
    repeat (2) @(negedge sys_clk);
    check("rst_wr_gnt", 64'(wr_gnt), 64'd0);
    check("rst_rd_gnt", 64'(rd_gnt), 64'd0);
    check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    check("rst_overdue", 64'(rf_overdue), 64'd0);
    check("rst_cmd_op", 64'(cmd_op), 64'd0);
    check("rst_cmd_addr", 64'(cmd_addr), 64'd0);
    check("rst_cmd_len", 64'(cmd_len), 64'd0);

    // Idle refresh cadence
    ack_dly = 1; done_dly = 8;
    cmd_cyc_q.delete();
    repeat (3) exp_cmd_q.push_back(mk(2'b10, '0, '0));
    sys_rst = 1'b1;
    repeat (3 * RC + 50) @(negedge sys_clk);
    check("rf_count", 64'(cmd_cyc_q.size()), 64'd3);
    if (cmd_cyc_q.size() == 3) begin
      check("rf_space1", 64'(cmd_cyc_q[1] - cmd_cyc_q[0]), 64'(RC));
      check("rf_space2", 64'(cmd_cyc_q[2] - cmd_cyc_q[1]), 64'(RC));
    end
    check("rf_no_overdue", 64'(rf_overdue), 64'd0);
    queues_empty("rf");

    // Single write, ack two cycles after cmd_valid
    do_reset();
    ack_dly = 2; done_dly = 3;
    exp_cmd_q.push_back(mk(2'b00, 24'h000100, 9'd256));
    exp_gnt_q.push_back(8'h57);
    wr_req = 1'b1; wr_addr = 24'h000100; wr_len = 9'd256;
    @(negedge sys_clk);
    check("wr_valid_latency", 64'(cmd_valid), 64'd1);
    @(negedge sys_clk);
    check("wr_valid_held", 64'(cmd_valid), 64'd1);
    req_xfer(1'b0, 24'h000100, 9'd256, 20);
    wr_req = 1'b0;
    repeat (10) @(negedge sys_clk);
    queues_empty("wr");

    // Continuous writes and reads: starvation bound
    do_reset();
    ack_dly = 1; done_dly = 2;
    for (int unsigned k = 0; k < 2; k++) begin
      for (int unsigned i = 0; i < 4; i++) begin
        exp_cmd_q.push_back(mk(2'b00, 24'h010000 + 24'(4 * k + i), 9'd16 + 9'(4 * k + i)));
        exp_gnt_q.push_back(8'h57);
      end
      exp_cmd_q.push_back(mk(2'b01, 24'h200000 + 24'(k), 9'd8));
      exp_gnt_q.push_back(8'h52);
    end
    fork
      begin
        for (int unsigned i = 0; i < 8; i++)
          req_xfer(1'b0, 24'h010000 + 24'(i), 9'd16 + 9'(i), 200);
        wr_req = 1'b0;
      end
      begin
        for (int unsigned j = 0; j < 2; j++)
          req_xfer(1'b1, 24'h200000 + 24'(j), 9'd8, 400);
        rd_req = 1'b0;
      end
    join
    repeat (10) @(negedge sys_clk);
    queues_empty("starve");

    // Zero-length read: grant without a command, FSM stays idle
    do_reset();
    ack_dly = 1; done_dly = 1;
    exp_gnt_q.push_back(8'h52);
    req_xfer(1'b1, 24'h000055, 9'd0, 1);
    check("zl_no_valid", 64'(cmd_valid), 64'd0);
    rd_req = 1'b0;
    exp_cmd_q.push_back(mk(2'b00, 24'h000077, 9'd3));
    exp_gnt_q.push_back(8'h57);
    wr_req = 1'b1; wr_addr = 24'h000077; wr_len = 9'd3;
    @(negedge sys_clk);
    check("zl_then_idle", 64'(cmd_valid), 64'd1);
    req_xfer(1'b0, 24'h000077, 9'd3, 20);
    wr_req = 1'b0;
    repeat (10) @(negedge sys_clk);
    queues_empty("zl");

    // Withheld cmd_done: refresh backlog saturates, then drains ahead of data
    do_reset();
    ack_dly = 1; done_dly = 9 * RC;
    exp_cmd_q.push_back(mk(2'b00, 24'h123456, 9'd100));
    exp_gnt_q.push_back(8'h57);
    repeat (7) exp_cmd_q.push_back(mk(2'b10, '0, '0));
    exp_cmd_q.push_back(mk(2'b00, 24'h00abcd, 9'd5));
    exp_gnt_q.push_back(8'h57);
    req_xfer(1'b0, 24'h123456, 9'd100, 20);
    wr_req = 1'b0;
    repeat (10) @(negedge sys_clk);
    done_dly = 1;
    repeat (7 * RC + 300) @(negedge sys_clk);
    check("sat_not_overdue", 64'(rf_overdue), 64'd0);
    repeat (RC) @(negedge sys_clk);
    check("sat_overdue", 64'(rf_overdue), 64'd1);
    req_xfer(1'b0, 24'h00abcd, 9'd5, 3 * RC);
    wr_req = 1'b0;
    repeat (10) @(negedge sys_clk);
    check("sat_overdue_sticky", 64'(rf_overdue), 64'd1);
    queues_empty("sat");

    // Reset during ISSUE
    do_reset();
    check("rst2_overdue", 64'(rf_overdue), 64'd0);
    eng_en = 1'b0;
    wr_req = 1'b1; wr_addr = 24'h0000aa; wr_len = 9'd10;
    @(negedge sys_clk);
    check("abort_valid", 64'(cmd_valid), 64'd1);
    #2 sys_rst = 1'b0;
    #1 check("abort_async_drop", 64'(cmd_valid), 64'd0);
    wr_req = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("abort_rst_op", 64'(cmd_op), 64'd0);
    check("abort_rst_addr", 64'(cmd_addr), 64'd0);
    check("abort_rst_len", 64'(cmd_len), 64'd0);
    check("abort_rst_gnt", 64'({wr_gnt, rd_gnt}), 64'd0);
    eng_en = 1'b1;
    exp_cmd_q.push_back(mk(2'b10, '0, '0));
    sys_rst = 1'b1;
    seen = 1'b0;
    n = 0;
    for (int unsigned c = 1; c <= RC + 20 && !seen; c++) begin
      @(negedge sys_clk);
      if (cmd_valid) begin
        seen = 1'b1;
        n = c;
      end
    end
    check("timer_restart", 64'(n), 64'(RC + 1));
    repeat (10) @(negedge sys_clk);
    queues_empty("abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dsl_sdram_arbiter.md
# dsl_sdram_arbiter

Schedules all access to the single 16-bit SDRAM (MT48LC16M16A2) between three sources: the capture path writing samples, the USB slave-FIFO readback path, and periodic auto-refresh. It sits between those requesters and the SDRAM command engine in the 120 MHz SDRAM clock domain. It issues exactly one burst command at a time, guarantees refresh cadence, and bounds readback starvation during capture.

## Interface
- REFRESH_CYCLES, 937, clocks between refresh ticks (7.8 us at 120 MHz)
- ADDR_W, 24, word address width
- LEN_W, 9, burst length field width (words, 1..256)
- MAX_STARVE, 4, consecutive write grants allowed while rd_req is waiting
- RF_MAX, 7, saturation value of the pending-refresh counter

- sys_clk  in  1  SDRAM-domain clock; all logic rising-edge
- sys_rst  in  1  reset; asynchronous assert, active-low (0 = reset)
- wr_req  in  1  capture write request; held until wr_gnt
- wr_addr  in  ADDR_W  write start address; stable while wr_req
- wr_len  in  LEN_W  write length in words
- wr_gnt  out  1  one-cycle grant pulse
- rd_req / rd_addr / rd_len / rd_gnt  same as the write set, for USB readback
- cmd_valid  out  1  command presented to the engine
- cmd_op  out  2  00 write, 01 read, 10 refresh
- cmd_addr  out  ADDR_W  latched address (0 for refresh)
- cmd_len  out  LEN_W  latched length (0 for refresh)
- cmd_ack  in  1  engine accepted command
- cmd_done  in  1  engine finished the command
- rf_overdue  out  1  sticky: a refresh tick arrived while rf_pend = RF_MAX

## Operation
- Refresh timer counts down from REFRESH_CYCLES-1. At 0 it reloads and increments rf_pend, saturating at RF_MAX. An increment attempted at saturation sets rf_overdue, which stays set until reset.
- FSM states are IDLE, ISSUE, and BUSY.
- IDLE selects one source, in priority order:
  - refresh if rf_pend > 0;
  - else read if rd_req and starve_cnt = MAX_STARVE;
  - else write if wr_req;
  - else read if rd_req;
  - else stay in IDLE.
- On selection, latch op/addr/len into cmd_* and go to ISSUE.
- ISSUE: cmd_valid = 1 and cmd_* are held until cmd_ack.
  - In the ack cycle, pulse the matching gnt (wr_gnt or rd_gnt; none for refresh). For refresh, decrement rf_pend.
  - Go to BUSY, or straight to IDLE if cmd_done is asserted in the same cycle.
- BUSY: cmd_valid = 0. Wait for cmd_done, then go to IDLE. cmd_done outside ISSUE/BUSY is ignored.
- starve_cnt: on a write grant with rd_req high, increment (saturating at MAX_STARVE). On a read grant, clear. If rd_req is low at a write grant, clear.
- Zero length: a wr_len or rd_len of 0 is granted from IDLE with a one-cycle gnt pulse, issues no command, and the FSM stays in IDLE. It still follows the priority and starvation rules.
- Simultaneous refresh tick and refresh ack: rf_pend is unchanged.

## Timing
- Reset values: wr_gnt = rd_gnt = cmd_valid = rf_overdue = 0; cmd_op = 00; cmd_addr = cmd_len = 0; rf_pend = 0; starve_cnt = 0; timer = REFRESH_CYCLES-1; FSM in IDLE.
- A request sampled high in IDLE at edge n gives cmd_valid high after edge n+1.
- gnt is registered, visible in the cycle after the ack edge. Requesters may drop req or change addr from that point.
- Minimum turnaround is 3 cycles (IDLE→ISSUE→BUSY→IDLE), or 2 cycles if ack and done coincide.
- A refresh tick arriving during ISSUE/BUSY of a data command is served at the next IDLE, ahead of any data request.
- Reset asserted mid-command drops cmd_valid asynchronously. No gnt is issued for the aborted command.
- Worst-case read wait under continuous writes is MAX_STARVE write commands plus pending refreshes.

## Test plan
- Reset, then idle for 3×REFRESH_CYCLES with the engine acking in 1 cycle and finishing after 8 → exactly 3 refresh commands (cmd_op = 10), each spaced 937 cycles; rf_overdue = 0.
- wr_req with addr 0x000100, len 256, ack 2 cycles later → cmd_valid 1 cycle after the request; cmd_op = 00, cmd_addr = 0x000100, cmd_len = 256; one wr_gnt pulse.
- wr_req and rd_req held continuously → grant sequence W, W, W, W, R, W, W, W, W, R… (MAX_STARVE = 4).
- Engine withholds cmd_done for 9×REFRESH_CYCLES → rf_pend saturates at 7, then rf_overdue is set. After done, the 7 refreshes issue back-to-back before any data command.
- rd_len = 0 → rd_gnt pulses with no cmd_valid; the FSM remains in IDLE.
- sys_rst pulled low while in ISSUE → cmd_valid = 0 immediately; after release all outputs are at their reset values and the timer restarts from 936.
